// File: rtl/key_dispatch_reader.sv
// key_dispatch_reader: snapshots a stored key and streams it LSW-first over valid/ready, scrubbing after each use.
// Optional abort input enabled by defining KEY_DISPATCH_ABORT_EN.
module key_dispatch_reader #(
    parameter int KEY_W    = 128,
    parameter int WORD_W   = 32,
    parameter int MAX_USES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_available,
    input  logic              req,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef KEY_DISPATCH_ABORT_EN
    input  logic              abort,
`endif
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              key_release,
    output logic              req_err,
    output logic [7:0]        uses_left
);
    localparam int NW = KEY_W / WORD_W;
    localparam int IW = NW > 1 ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE, SEND, SCRUB} state_t;

    state_t            r_state, w_next;
    logic [KEY_W-1:0]  r_shadow;
    logic [IW-1:0]     r_idx;
    logic [7:0]        r_cnt;
    logic              r_done, r_release, r_req_err, r_aborted;
    logic              w_fire, w_last, w_abort, w_start;

`ifdef KEY_DISPATCH_ABORT_EN
    assign w_abort = abort && r_state == SEND;
`else
    assign w_abort = 1'b0;
`endif

    assign w_start = r_state == IDLE && req && key_available;
    assign w_fire  = out_valid && out_ready;
    assign w_last  = r_idx == IW'(NW - 1);

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE)  ? (w_start ? SEND : IDLE) :
                 (r_state == SEND)  ? ((w_abort || (w_fire && w_last)) ? SCRUB : SEND) :
                 IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // The shadow shifts down on each handshake so the low word is always the one on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_release <= 1'b0;
            r_req_err <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_release <= 1'b0;
            r_req_err <= r_state == IDLE && req && !key_available;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shadow  <= key_in;
                        r_idx     <= '0;
                        r_aborted <= 1'b0;
                    end
                end
                SEND: begin
                    if (w_abort) begin
                        r_aborted <= 1'b1;
                    end else if (w_fire) begin
                        r_shadow <= r_shadow >> WORD_W;
                        r_idx    <= r_idx + 1'b1;
                    end
                end
                SCRUB: begin
                    r_shadow  <= '0;
                    r_idx     <= '0;
                    r_aborted <= 1'b0;
                    if (r_aborted) begin
                        r_req_err <= 1'b1;
                    end else begin
                        r_done <= 1'b1;
                        if (r_cnt == 8'(MAX_USES - 1)) begin
                            r_cnt     <= '0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: r_shadow <= '0;
            endcase
        end
    end

    assign out_valid   = r_state == SEND;
    assign out_word    = out_valid ? r_shadow[WORD_W-1:0] : '0;
    assign out_last    = out_valid && w_last;
    assign busy        = r_state != IDLE;
    assign done        = r_done;
    assign key_release = r_release;
    assign req_err     = r_req_err;
    assign uses_left   = 8'(MAX_USES) - r_cnt;
endmodule

// File: tb/tb_key_dispatch_reader.sv
// tb_key_dispatch_reader: scoreboard bench; stimulus queues expected words, a negedge monitor checks them.
module tb_key_dispatch_reader;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_available = 1'b0;
    logic         req = 1'b0;
    logic [31:0]  out_word;
    logic         out_valid;
    logic         out_ready = 1'b1;
`ifdef KEY_DISPATCH_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic         out_last, busy, done, key_release, req_err;
    logic [7:0]   uses_left;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [31:0] prev_word = '0;

    localparam logic [127:0] K1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] K2 = 128'hDEADBEEF_01234567_89ABCDEF_A5A55A5A;
    localparam logic [127:0] K3 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] K4 = 128'hCAFEF00D_0BADC0DE_FEEDFACE_12345678;

    key_dispatch_reader dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_available(key_available), .req(req),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
`ifdef KEY_DISPATCH_ABORT_EN
        .abort(abort),
`endif
        .out_last(out_last), .busy(busy), .done(done), .key_release(key_release),
        .req_err(req_err), .uses_left(uses_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!out_valid)
                chk("word_zero_when_idle", 128'(out_word), 128'h0);
            if (stall_prev && out_valid)
                chk("word_held_in_stall", 128'(out_word), 128'(prev_word));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 128'(out_word), 128'h0 - 128'h1);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("out_word", 128'(out_word), 128'(e[31:0]));
                    chk("out_last", 128'(out_last), 128'(e[32]));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_word  = out_word;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic push_words(input logic [127:0] k, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({1'(i == 3), k[i*32 +: 32]});
    endtask

    task automatic dispatch(input logic [127:0] k, input int sw, input int sn, input int exp_lat,
                            input logic [7:0] exp_uses, input logic exp_rel);
        int lat;
        lat = 0;
        push_words(k, 4);
        key_in = k;
        key_available = 1'b1;
        req = 1'b1;
        out_ready = 1'b1;
        do begin
            tick();
            lat++;
            req = 1'b0;
            if (lat == 1)
                chk("busy_in_send", 128'(busy), 128'h1);
            out_ready = !(sn > 0 && lat >= 1 + sw && lat < 1 + sw + sn);
        end while (!done && lat < 40);
        out_ready = 1'b1;
        chk("done_latency", 128'(lat), 128'(exp_lat));
        chk("uses_left", 128'(uses_left), 128'(exp_uses));
        chk("key_release", 128'(key_release), 128'(exp_rel));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_out_valid", 128'(out_valid), 128'h0);
        chk("rst_out_word", 128'(out_word), 128'h0);
        chk("rst_uses_left", 128'(uses_left), 128'd4);
        chk("rst_busy", 128'(busy), 128'h0);
        chk("rst_done", 128'(done), 128'h0);
        rst = 1'b0;
        tick();

        dispatch(K1, 0, 0, 6, 8'd3, 1'b0);
        tick();
        chk("done_one_cycle", 128'(done), 128'h0);
        dispatch(K1, 1, 3, 9, 8'd2, 1'b0);
        chk("shadow_scrubbed", dut.r_shadow, 128'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        dispatch(K1, 0, 0, 6, 8'd3, 1'b0);
        dispatch(K2, 0, 0, 6, 8'd2, 1'b0);
        dispatch(K3, 0, 0, 6, 8'd1, 1'b0);
        dispatch(K4, 2, 2, 8, 8'd4, 1'b1);
        tick();
        chk("release_one_cycle", 128'(key_release), 128'h0);

        key_available = 1'b0;
        req = 1'b1;
        tick();
        req = 1'b0;
        chk("req_err_pulse", 128'(req_err), 128'h1);
        chk("req_err_no_valid", 128'(out_valid), 128'h0);
        chk("req_err_not_busy", 128'(busy), 128'h0);
        tick();
        chk("req_err_one_cycle", 128'(req_err), 128'h0);

        push_words(K3, 2);
        key_in = K3;
        key_available = 1'b1;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 128'(out_valid), 128'h0);
        chk("async_rst_word", 128'(out_word), 128'h0);
        chk("async_rst_busy", 128'(busy), 128'h0);
        chk("async_rst_uses", 128'(uses_left), 128'd4);
        chk("async_rst_shadow", dut.r_shadow, 128'h0);
        tick();
        rst = 1'b0;
        tick();
        dispatch(K4, 0, 0, 6, 8'd3, 1'b0);

`ifdef KEY_DISPATCH_ABORT_EN
        push_words(K2, 2);
        key_in = K2;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid_drop", 128'(out_valid), 128'h0);
        tick();
        chk("abort_req_err", 128'(req_err), 128'h1);
        chk("abort_no_done", 128'(done), 128'h0);
        chk("abort_uses_left", 128'(uses_left), 128'd3);
        chk("abort_shadow", dut.r_shadow, 128'h0);
        out_ready = 1'b1;
        tick();
`endif

        tick();
        chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
